// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller and datapath.
// Holds the state encoding, the opcode constants, the datapath mux select
// encodings and the control-word bundle produced by mc_ctrl_decode.
package mc_ctrl_pkg;

  localparam int OPW_DEF = 6;
  localparam int STW_DEF = 4;

  // Controller states; 13..15 are unreachable encodings.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  // Opcodes (IR[31:26]).
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALU A-side source.
  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_A    = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  // ALU B-side source.
  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  // ALU operation class.
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  // Next-PC source.
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // Full control word for one state (PCEn is derived separately with Zero).
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure combinational State -> control-word decoder for multicycle_control.
// Ports:
//   state_i : current controller state
//   ctrl_o  : every datapath select/enable for that state (unlisted fields 0)
// Optional feature macro: ILLEGAL_TRAP_EN (TRAP state raises illegal_op).
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  // Moore decode: start from an all-zero word so only listed fields are set.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.alu_src_a = SRCA_PC;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.pc_write  = 1'b1;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        ctrl_o.alu_src_a = SRCA_PC;
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = SRCA_A;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = SRCA_A;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = SRCA_A;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        ctrl_o.alu_src_a = SRCA_A;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b0;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        ctrl_o.illegal_op = 1'b1;
`else
        ctrl_o.illegal_op = 1'b0;
`endif
      end
      default: begin
        // Unreachable encodings: every strobe stays 0.
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM sequencing the multicycle MIPS-subset datapath.
// Holds the state register and next-state logic; per-state outputs come from
// mc_ctrl_decode. Only PCEn additionally depends on the Zero input.
// Ports: clk/reset (sync, active-high), Op (IR opcode), Zero (ALU flag);
//   outputs PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
//   State (debug) and IllegalOp.
// Optional feature macro: ILLEGAL_TRAP_EN -- unknown opcodes enter a sticky
//   TRAP state with IllegalOp=1; when undefined they act as a 2-cycle NOP.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] Op,
  input  logic           Zero,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           PCEn,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           MemtoReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic [1:0]     ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSource,
  output logic [STW-1:0] State,
  output logic           IllegalOp
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_s;

  // State register; reset overrides any in-flight transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; Op is only consulted in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        if (Op == OP_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`else
      S_TRAP:   state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl_s)
  );

  assign PCWrite     = ctrl_s.pc_write;
  assign PCWriteCond = ctrl_s.pc_write_cond;
  assign PCEn        = ctrl_s.pc_write | (ctrl_s.pc_write_cond & Zero);
  assign IorD        = ctrl_s.iord;
  assign MemRead     = ctrl_s.mem_read;
  assign MemWrite    = ctrl_s.mem_write;
  assign IRWrite     = ctrl_s.ir_write;
  assign MemtoReg    = ctrl_s.mem_to_reg;
  assign RegDst      = ctrl_s.reg_dst;
  assign RegWrite    = ctrl_s.reg_write;
  assign ALUSrcA     = ctrl_s.alu_src_a;
  assign ALUSrcB     = ctrl_s.alu_src_b;
  assign ALUOp       = ctrl_s.alu_op;
  assign PCSource    = ctrl_s.pc_source;
  assign State       = STW'(state_q);
  assign IllegalOp   = ctrl_s.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic       Zero;
  logic       PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, IllegalOp;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.OPW(6), .STW(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .State(State), .IllegalOp(IllegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, pcwc, pcen, iord, mr, mw, irw, m2r, rdst, rw;
    logic [1:0] srca, srcb, aluop, pcsrc;
    logic       ill;
  } obs_t;

  typedef struct {
    logic [5:0]  op;
    int          zmode;   // 0/1 fixed Zero, 2 random
    int          len;
    logic [23:0] seq;     // expected State per cycle, nibble k = cycle k
  } vec_t;

  // Expected outputs for a state, straight from the per-state output list.
  function automatic obs_t exp_out(input int st, input logic z);
    obs_t o;
    o = '0;
    case (st)
      0:  begin o.mr = 1'b1; o.irw = 1'b1; o.srcb = 2'd1; o.pcw = 1'b1; end
      1:  begin o.srcb = 2'd3; end
      2:  begin o.srca = 2'd1; o.srcb = 2'd2; end
      3:  begin o.mr = 1'b1; o.iord = 1'b1; end
      4:  begin o.rw = 1'b1; o.m2r = 1'b1; end
      5:  begin o.mw = 1'b1; o.iord = 1'b1; end
      6:  begin o.srca = 2'd1; o.aluop = 2'd2; end
      7:  begin o.rw = 1'b1; o.rdst = 1'b1; end
      8:  begin o.srca = 2'd1; o.aluop = 2'd1; o.pcwc = 1'b1; o.pcsrc = 2'd1; end
      9:  begin o.pcw = 1'b1; o.pcsrc = 2'd2; end
      10: begin o.srca = 2'd1; o.srcb = 2'd2; end
      11: begin o.rw = 1'b1; end
`ifdef ILLEGAL_TRAP_EN
      12: begin o.ill = 1'b1; end
`endif
      default: ;
    endcase
    o.pcen = o.pcw | (o.pcwc & z);
    return o;
  endfunction

  // Instruction-level model: State trace from FETCH for a given opcode.
  function automatic void model_seq(input logic [5:0] op, output int len,
                                    output logic [23:0] seq, output bit trap);
    int s[$];
    s = {0, 1};
    trap = 1'b0;
    if (op == 6'b100011)      s = {s, 2, 3, 4};
    else if (op == 6'b101011) s = {s, 2, 5};
    else if (op == 6'b000000) s = {s, 6, 7};
    else if (op == 6'b001000) s = {s, 10, 11};
    else if (op == 6'b000100) s.push_back(8);
    else if (op == 6'b000010) s.push_back(9);
    else begin
`ifdef ILLEGAL_TRAP_EN
      s = {s, 12, 12};
      trap = 1'b1;
`endif
    end
    len = s.size();
    seq = '0;
    foreach (s[i]) seq[i*4 +: 4] = 4'(s[i]);
  endfunction

  task automatic check(input int exp_st, input string tag);
    obs_t a, e;
    a = {PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite,
         MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};
    e = exp_out(exp_st, Zero);
    checks++;
    if (State !== 4'(exp_st)) begin
      errors++;
      $display("FAIL %s state: got %0d expected %0d", tag, State, exp_st);
    end
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s outputs (state %0d zero %0b): got %h expected %h",
               tag, exp_st, Zero, a, e);
    end
    checks++;
    if (ALUSrcA === 2'd3) begin
      errors++;
      $display("FAIL %s alusrca: got 3 expected not 3", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction starting at FETCH; optionally reset on its last cycle.
  task automatic run_seq(input logic [5:0] op, input int zmode, input int len,
                         input logic [23:0] seq, input bit trap, input string tag);
    Op = op;
    for (int k = 0; k < len; k++) begin
      Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      check(int'(seq[k*4 +: 4]), tag);
      if (trap && (k == len - 1)) reset = 1'b1;
      step();
      reset = 1'b0;
    end
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(input logic [5:0] op, input int z, input int len,
                              input int s0, input int s1, input int s2,
                              input int s3, input int s4);
    vec_t v;
    v.op = op; v.zmode = z; v.len = len;
    v.seq = {4'd0, 4'(s4), 4'(s3), 4'(s2), 4'(s1), 4'(s0)};
    return v;
  endfunction

  initial begin
    logic [5:0]  rop;
    int          rlen;
    logic [23:0] rseq;
    bit          rtrap;
    logic [5:0]  known[6];

    known = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};

    vecs.push_back(mk(6'b100011, 0, 5, 0, 1, 2, 3, 4));   // lw
    vecs.push_back(mk(6'b101011, 1, 4, 0, 1, 2, 5, 0));   // sw
    vecs.push_back(mk(6'b000000, 0, 4, 0, 1, 6, 7, 0));   // R-type
    vecs.push_back(mk(6'b001000, 1, 4, 0, 1, 10, 11, 0)); // addi back-to-back
    vecs.push_back(mk(6'b000100, 1, 3, 0, 1, 8, 0, 0));   // beq taken
    vecs.push_back(mk(6'b000100, 0, 3, 0, 1, 8, 0, 0));   // beq not taken
    vecs.push_back(mk(6'b000010, 0, 3, 0, 1, 9, 0, 0));   // j
`ifndef ILLEGAL_TRAP_EN
    vecs.push_back(mk(6'b111111, 1, 2, 0, 1, 0, 0, 0));   // unknown -> NOP
`endif
    vecs.push_back(mk(6'b000000, 1, 4, 0, 1, 6, 7, 0));   // FETCH follows NOP

    // Reset held two cycles.
    reset = 1'b1; Op = 6'b000000; Zero = 1'b0;
    step();
    step();
    check(0, "reset");
    reset = 1'b0;

    // Table vectors, back to back.
    for (int i = 0; i < vecs.size(); i++) begin
      run_seq(vecs[i].op, vecs[i].zmode, vecs[i].len, vecs[i].seq, 1'b0,
              $sformatf("vec%0d", i));
    end

    // sw interrupted in MEMADR must never reach MEMWR.
    Op = 6'b101011; Zero = 1'b0;
    #1; check(0, "sw_abort_fetch");
    step(); check(1, "sw_abort_decode");
    step(); check(2, "sw_abort_memadr");
    reset = 1'b1;
    step();
    reset = 1'b0;
    check(0, "sw_abort_reset");
    step(); check(1, "sw_resume_decode");
    step(); check(2, "sw_resume_memadr");
    step(); check(5, "sw_resume_memwr");
    step();

`ifdef ILLEGAL_TRAP_EN
    // Unknown opcode traps and holds until reset.
    Op = 6'b111111; Zero = 1'b1;
    #1; check(0, "trap_fetch");
    step(); check(1, "trap_decode");
    for (int i = 0; i < 10; i++) begin
      step(); check(12, "trap_hold");
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check(0, "trap_exit");
`endif

    // Randomized instruction stream against the instruction-level model.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do rop = 6'($urandom);
        while (rop inside {known});
      end else begin
        rop = known[$urandom_range(0, 5)];
      end
      model_seq(rop, rlen, rseq, rtrap);
      run_seq(rop, 2, rlen, rseq, rtrap, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-style control FSM that sequences the multicycle MIPS-subset datapath. It decodes the IR opcode field and, per state, drives every datapath select and enable:
- PC/address muxes
- ALU source muxes (ALUSrcA feeds the A-side ALU mux)
- register-file and memory strobes

It sits between the instruction register and all datapath muxes/registers. It is the only driver of their select lines.

Parameters:
- OPW, 6, opcode field width
- STW, 4, state register width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Op  input  6  IR[31:26] opcode
- Zero  input  1  ALU zero flag, valid in BRANCH state
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by Zero
- PCEn  output  1  PCWrite | (PCWriteCond & Zero)
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  write-back select: 0=ALUOut, 1=MDR
- RegDst  output  1  destination select: 0=rt, 1=rd
- RegWrite  output  1  register-file write enable
- ALUSrcA  output  2  0=PC, 1=A register, 2=zero constant; 3 never driven
- ALUSrcB  output  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- ALUOp  output  2  0=add, 1=sub, 2=funct-decoded
- PCSource  output  2  0=ALU result, 1=ALUOut, 2=jump target
- State  output  4  current state, for debug
- IllegalOp  output  1  trap flag (ILLEGAL_TRAP_EN only, otherwise tied 0)

Behaviour:
- Single state register updated on posedge clk. reset=1 forces FETCH on the next edge, overriding any transition, including mid-instruction. An interrupted store never reaches MEMWR.
- All outputs are a pure combinational decode of State. They are not a function of Op or Zero, except PCEn, which uses Zero.
- Unlisted outputs are 0 in each state.
- Reset output values are the FETCH values.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12
- FETCH: MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target into ALUOut). Next state by Op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDIEX
  - any other opcode -> see Optional Feature
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next state is MEMRD if Op=lw, otherwise MEMWR.
- MEMRD: MemRead=1, IorD=1. Next state is MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state is FETCH.
- MEMWR: MemWrite=1, IorD=1. Next state is FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Next state is ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1. Next state is FETCH.
- JUMP: PCWrite=1, PCSource=2. Next state is FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next state is ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next state is FETCH.
- Latency in cycles, FETCH through the final state inclusive: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3.
- Op is sampled in DECODE and MEMADR only. The IR is stable because IRWrite is 0 outside FETCH.
- Unreachable encodings (13-15) -> FETCH next cycle, with all strobes 0.
- MemRead and MemWrite are never both 1. RegWrite and PCWrite are never both 1.

Optional Feature:
- ILLEGAL_TRAP_EN defined:
  - unknown opcode in DECODE -> TRAP
  - TRAP holds all strobes 0 and IllegalOp=1
  - TRAP self-loops until reset
- ILLEGAL_TRAP_EN undefined:
  - unknown opcode -> FETCH, so the instruction acts as a 2-cycle NOP (PC already advanced)
  - IllegalOp tied 0
  - TRAP encoding unused

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state encoding constants
  - opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI)
  - ALUSrcA/ALUSrcB/PCSource/ALUOp encoding constants
  - these are also used by the datapath muxes
- One sub-module is natural: mc_ctrl_decode, a pure combinational State->control-word decoder. The top module keeps the state register and the next-state logic.

Test Plan:
- reset=1 for 2 cycles, then released -> State=0, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=1 at the first post-reset cycle.
- Op=100011 (lw) -> State sequence 0,1,2,3,4,0. MEMRD has IorD=1, MemRead=1. MEMWB has RegWrite=1, MemtoReg=1.
- Op=000100 (beq): Zero=1 in BRANCH -> PCEn=1, PCSource=1. Repeat with Zero=0 -> PCEn=0. Total 3 cycles each.
- Op=101011 (sw), reset asserted while in MEMADR -> next State=0 and MemWrite never asserted.
- Op=000000 then 001000 back-to-back -> sequences 0,1,6,7 then 0,1,10,11. ALUSrcA=1 in EXEC and in ADDIEX. ALUSrcA is never 3 in any cycle.
- Op=111111:
  - ILLEGAL_TRAP_EN defined -> State=12, IllegalOp=1, held for 10 cycles until reset.
  - ILLEGAL_TRAP_EN undefined -> State 0,1,0, IllegalOp=0.
